// File: rtl/frog_pixel_renderer_pkg.sv
// Shared constants for the frog pixel renderer: grid geometry, lane map,
// palette and spawn position.
package frog_pixel_renderer_pkg;

   localparam int H_ACTIVE   = 640;
   localparam int V_ACTIVE   = 480;
   localparam int TILE_LOG2  = 5;
   localparam int BLINK_LOG2 = 4;

   localparam int GRID_COLS = 20;
   localparam int GRID_ROWS = 15;

   localparam logic [4:0] MAX_COL   = 5'(GRID_COLS - 1);
   localparam logic [3:0] MAX_ROW   = 4'(GRID_ROWS - 1);
   localparam logic [4:0] SPAWN_COL = 5'd9;
   localparam logic [3:0] SPAWN_ROW = 4'd14;

   localparam logic [3:0] GOAL_ROW    = 4'd0;
   localparam logic [3:0] WATER_FIRST = 4'd1;
   localparam logic [3:0] WATER_LAST  = 4'd6;
   localparam logic [3:0] SAFE_ROW    = 4'd7;
   localparam logic [3:0] ROAD_FIRST  = 4'd8;
   localparam logic [3:0] ROAD_LAST   = 4'd13;
   localparam logic [3:0] START_ROW   = 4'd14;

   typedef enum logic [2:0] {
      LANE_NONE,
      LANE_GOAL,
      LANE_WATER,
      LANE_SAFE,
      LANE_ROAD,
      LANE_START
   } lane_e;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   localparam rgb_t COL_BLACK = '{r: 3'd0, g: 3'd0, b: 3'd0};
   localparam rgb_t COL_GOAL  = '{r: 3'd0, g: 3'd5, b: 3'd0};
   localparam rgb_t COL_WATER = '{r: 3'd0, g: 3'd0, b: 3'd5};
   localparam rgb_t COL_SAFE  = '{r: 3'd3, g: 3'd3, b: 3'd1};
   localparam rgb_t COL_ROAD  = '{r: 3'd2, g: 3'd2, b: 3'd2};
   localparam rgb_t COL_FROG  = '{r: 3'd0, g: 3'd7, b: 3'd0};

   function automatic lane_e lane_of(input logic [3:0] row);
      if (row == GOAL_ROW)                             return LANE_GOAL;
      else if (row >= WATER_FIRST && row <= WATER_LAST) return LANE_WATER;
      else if (row == SAFE_ROW)                        return LANE_SAFE;
      else if (row >= ROAD_FIRST && row <= ROAD_LAST)   return LANE_ROAD;
      else if (row == START_ROW)                       return LANE_START;
      else                                             return LANE_NONE;
   endfunction

   function automatic rgb_t lane_colour(input lane_e lane);
      case (lane)
         LANE_GOAL:              return COL_GOAL;
         LANE_WATER:             return COL_WATER;
         LANE_SAFE, LANE_START:  return COL_SAFE;
         LANE_ROAD:              return COL_ROAD;
         default:                return COL_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/frog_pixel_renderer_sprite_rom.sv
// 8x8 frog bitmap; row word MSB is the leftmost pixel (sub_x = 0).
module frog_sprite_rom (
   input  logic [2:0] i_sub_x,
   input  logic [2:0] i_sub_y,
   output logic       o_pixel
);

   logic [7:0] w_line;

   always_comb begin
      // NOTE: assigning a default before the case keeps this block purely combinational (no latch).
      w_line = 8'h00;
      case (i_sub_y)
         3'd0: w_line = 8'b0110_0110;
         3'd1: w_line = 8'b1111_1111;
         3'd2: w_line = 8'b0111_1110;
         3'd3: w_line = 8'b1101_1011;
         3'd4: w_line = 8'b0111_1110;
         3'd5: w_line = 8'b0011_1100;
         3'd6: w_line = 8'b0111_1110;
         3'd7: w_line = 8'b1100_0011;
      endcase
   end

   assign o_pixel = w_line[3'd7 - i_sub_x];

endmodule

// File: rtl/frog_pixel_renderer.sv
// Pixel-colour stage ahead of the VGA pins: lane background plus frog sprite,
// two-cycle pipeline with frame-synchronous position latch and hit blink.
module frog_pixel_renderer
   import frog_pixel_renderer_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] pix_x,
   input  logic [9:0] pix_y,
   input  logic       pix_active,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       frame_start,
   input  logic [4:0] player_col,
   input  logic [3:0] player_row,
   input  logic       player_hit,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] red,
   output logic [2:0] green,
   output logic [2:0] blue
);

   logic [4:0]          r_lat_col;
   logic [3:0]          r_lat_row;
   logic                r_lat_hit;
   logic [BLINK_LOG2:0] r_frame_cnt;

   logic [4:0] w_clamp_col;
   logic [3:0] w_clamp_row;

   assign w_clamp_col = (player_col > MAX_COL) ? MAX_COL : player_col;
   assign w_clamp_row = (player_row > MAX_ROW) ? MAX_ROW : player_row;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lat_col   <= SPAWN_COL;
         r_lat_row   <= SPAWN_ROW;
         r_lat_hit   <= 1'b0;
         r_frame_cnt <= '0;
      end else if (frame_start) begin
         // NOTE: non-blocking so pixels entering stage 1 this cycle still see the old position.
         r_lat_col   <= w_clamp_col;
         r_lat_row   <= w_clamp_row;
         r_lat_hit   <= player_hit;
         r_frame_cnt <= r_frame_cnt + {{BLINK_LOG2{1'b0}}, 1'b1};
      end
   end

   logic [4:0] w_tile_col;
   logic [3:0] w_tile_row;
   logic       w_in_grid;
   logic       w_blink_hide;
   logic       w_is_frog;
   lane_e      w_lane;

   assign w_tile_col   = pix_x[TILE_LOG2+4:TILE_LOG2];
   assign w_tile_row   = pix_y[TILE_LOG2+3:TILE_LOG2];
   assign w_in_grid    = (pix_x < 10'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));
   assign w_blink_hide = r_lat_hit && r_frame_cnt[BLINK_LOG2];
   assign w_is_frog    = w_in_grid && (w_tile_col == r_lat_col) &&
                         (w_tile_row == r_lat_row) && !w_blink_hide;
   assign w_lane       = w_in_grid ? lane_of(w_tile_row) : LANE_NONE;

   logic       r_s1_valid;
   logic       r_s1_hsync;
   logic       r_s1_vsync;
   logic       r_s1_is_frog;
   logic [2:0] r_s1_sub_x;
   logic [2:0] r_s1_sub_y;
   lane_e      r_s1_lane;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_hsync   <= 1'b1;
         r_s1_vsync   <= 1'b1;
         r_s1_is_frog <= 1'b0;
         r_s1_sub_x   <= '0;
         r_s1_sub_y   <= '0;
         r_s1_lane    <= LANE_NONE;
      end else begin
         r_s1_valid   <= pix_active;
         r_s1_hsync   <= hsync_in;
         r_s1_vsync   <= vsync_in;
         r_s1_is_frog <= w_is_frog;
         r_s1_sub_x   <= pix_x[TILE_LOG2-1:TILE_LOG2-3];
         r_s1_sub_y   <= pix_y[TILE_LOG2-1:TILE_LOG2-3];
         r_s1_lane    <= w_lane;
      end
   end

   logic w_sprite_bit;

   frog_sprite_rom u_sprite_rom (
      .i_sub_x (r_s1_sub_x),
      .i_sub_y (r_s1_sub_y),
      .o_pixel (w_sprite_bit)
   );

   rgb_t w_colour;

   always_comb begin
      w_colour = COL_BLACK;
      if (r_s1_valid) begin
         if (r_s1_is_frog && w_sprite_bit) w_colour = COL_FROG;
         else                              w_colour = lane_colour(r_s1_lane);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         red   <= '0;
         green <= '0;
         blue  <= '0;
      end else begin
         hsync <= r_s1_hsync;
         vsync <= r_s1_vsync;
         red   <= w_colour.r;
         green <= w_colour.g;
         blue  <= w_colour.b;
      end
   end

endmodule

// File: tb/tb_frog_pixel_renderer.sv
// Directed bench for frog_pixel_renderer; a small pixel model with its own copy
// of the lane map and bitmap supplies every expected {hsync,vsync,r,g,b}.
module tb_frog_pixel_renderer;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] pix_x;
   logic [9:0] pix_y;
   logic       pix_active;
   logic       hsync_in;
   logic       vsync_in;
   logic       frame_start;
   logic [4:0] player_col;
   logic [3:0] player_row;
   logic       player_hit;
   logic       hsync;
   logic       vsync;
   logic [2:0] red;
   logic [2:0] green;
   logic [2:0] blue;

   frog_pixel_renderer dut (
      .clk         (clk),
      .reset       (reset),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pix_active  (pix_active),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .frame_start (frame_start),
      .player_col  (player_col),
      .player_row  (player_row),
      .player_hit  (player_hit),
      .hsync       (hsync),
      .vsync       (vsync),
      .red         (red),
      .green       (green),
      .blue        (blue)
   );

   always #5 clk = ~clk;

   localparam logic [10:0] OUT_RESET = 11'b11_000_000_000;

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got hs/vs/rgb=%b expected %b", tag, got, exp);
      end
   endtask

   logic [7:0] bm [0:7] = '{8'b01100110, 8'b11111111, 8'b01111110, 8'b11011011,
                            8'b01111110, 8'b00111100, 8'b01111110, 8'b11000011};

   int m_col = 9;
   int m_row = 14;
   int m_hit = 0;
   int m_cnt = 0;

   function automatic logic [10:0] model(input int x, input int y, input bit act,
                                        input bit hs, input bit vs);
      logic [8:0] c;
      logic [7:0] line;
      int         row;
      bit         vis;
      c = 9'b000_000_000;
      if (act && x < 640 && y < 480) begin
         row = y >> 5;
         if (row == 0)                   c = 9'b000_101_000;
         else if (row <= 6)              c = 9'b000_000_101;
         else if (row == 7 || row == 14) c = 9'b011_011_001;
         else                            c = 9'b010_010_010;
         vis = !(m_hit != 0 && m_cnt >= 16);
         if (vis && (x >> 5) == m_col && row == m_row) begin
            line = bm[(y >> 2) & 7];
            if (line[7 - ((x >> 2) & 7)]) c = 9'b000_111_000;
         end
      end
      return {hs, vs, c};
   endfunction

   logic [10:0] expq[$];
   string       tagq[$];

   function automatic logic [10:0] outs();
      return {hsync, vsync, red, green, blue};
   endfunction

   // Drive one pixel, then check the pixel driven on the previous call (2-cycle latency).
   task automatic step(input int x, input int y, input bit act, input bit hs,
                       input bit vs, input bit fs, input string tag);
      pix_x       = x[9:0];
      pix_y       = y[9:0];
      pix_active  = act;
      hsync_in    = hs;
      vsync_in    = vs;
      frame_start = fs;
      expq.push_back(model(x, y, act, hs, vs));
      tagq.push_back(tag);
      if (fs) begin
         m_col = (player_col > 19) ? 19 : int'(player_col);
         m_row = (player_row > 14) ? 14 : int'(player_row);
         m_hit = int'(player_hit);
         m_cnt = (m_cnt + 1) % 32;
      end
      @(posedge clk);
      #1;
      if (expq.size() >= 2) check(tagq.pop_front(), outs(), expq.pop_front());
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      pix_x       = 10'd300;
      pix_y       = 10'd464;
      pix_active  = 1'b1;
      hsync_in    = 1'b0;
      vsync_in    = 1'b0;
      frame_start = 1'b0;
      player_col  = 5'd0;
      player_row  = 4'd0;
      player_hit  = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", outs(), OUT_RESET);
      reset = 1'b1;

      step(320, 464, 1, 1, 1, 0, "spawn_start_col10");
      check("first_cycle_not_valid", outs(), OUT_RESET);
      step(300, 464, 1, 1, 1, 0, "spawn_frog_bit");
      step(296, 464, 1, 1, 1, 0, "spawn_frog_bit2");
      step(288, 464, 1, 1, 1, 0, "spawn_frog_clear");

      for (int x = 0; x < 640; x++)
         step(x, 40, 1, !(x >= 600 && x < 616), 1, 0, "row1_sweep");

      player_col = 5'd3;
      player_row = 4'd8;
      step(300, 464, 1, 1, 1, 0, "midframe_old_frog");
      step(100, 260, 1, 1, 1, 0, "midframe_no_new");
      step(0, 480, 0, 1, 0, 1, "frame_start_1");
      for (int y = 256; y < 288; y++)
         for (int x = 96; x < 128; x++)
            step(x, y, 1, 1, 1, 0, "tile_3_8");
      step(95, 256, 1, 1, 1, 0, "tile_3_8_left_edge");
      step(128, 287, 1, 1, 1, 0, "tile_3_8_right_edge");
      step(100, 288, 1, 1, 1, 0, "tile_3_8_below");
      step(300, 464, 1, 1, 1, 0, "spawn_vacated");

      player_col = 5'd25;
      player_row = 4'd15;
      step(0, 480, 0, 1, 0, 1, "frame_start_clamp");
      for (int j = 0; j < 8; j++)
         for (int i = 0; i < 8; i++)
            step(608 + 4 * i + 1, 448 + 4 * j + 2, 1, 1, 1, 0, "clamp_tile_19_14");
      step(100, 260, 1, 1, 1, 0, "tile_3_8_vacated");

      player_col = 5'd5;
      player_row = 4'd3;
      player_hit = 1'b1;
      for (int f = 0; f < 64; f++) begin
         step(0, 480, 0, 1, 0, 1, "frame_start_blink");
         for (int j = 0; j < 8; j++)
            for (int i = 0; i < 8; i++)
               step(160 + 4 * i + 2, 96 + 4 * j + 1, 1, 1, 1, 0, "blink_tile_5_3");
      end
      player_hit = 1'b0;
      step(0, 480, 0, 1, 0, 1, "frame_start_nohit");

      step(700, 100, 0, 1, 1, 0, "inactive_x700");
      step(170, 100, 0, 1, 1, 0, "inactive_on_frog");
      step(300, 500, 1, 1, 1, 0, "row15_black");
      step(170, 520, 1, 1, 1, 0, "line520_black");
      step(170, 100, 1, 1, 1, 0, "frog_visible_again");

      step(100, 40, 1, 1, 1, 0, "pre_reset_pixel");
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_midline", outs(), OUT_RESET);
      expq.delete();
      tagq.delete();
      m_col = 9;
      m_row = 14;
      m_hit = 0;
      m_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_held_midline", outs(), OUT_RESET);
      reset = 1'b1;
      step(300, 464, 1, 1, 1, 0, "post_reset_spawn_frog");
      check("post_reset_first_cycle", outs(), OUT_RESET);
      step(170, 100, 1, 1, 1, 0, "post_reset_old_pos_water");
      step(700, 100, 0, 1, 1, 0, "flush");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
